key_entry: RTL and testbench

Keypad entry stage downstream of the 4x4 matrix scanner. Consumes the scanner's raw key-present flag `opr` and key position `posicion`, debounces press/release, emits one event per physical keystroke, and decodes the event into a decimal digit buffer, an operator register, clear and enter. Feeds the arithmetic/display logic.

---
 rtl/key_pkg.sv | 68 ++++++
 rtl/key_debounce.sv | 102 ++++++++++
 rtl/key_entry.sv | 128 ++++++++++++
 tb/tb_key_entry.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// ---------------------------------------------------------------------------
// key_pkg
// Shared definitions for the keypad entry stage:
//   - operator codes for the A/B/C/D keys
//   - key class enum and the decoded-key struct
//   - decode_key(): maps a row-major scanner position (0..15) to class/value
//   - debounce FSM state enum
// ---------------------------------------------------------------------------
package key_pkg;

    // Operator codes as latched into the op register
    localparam logic [1:0] OP_A = 2'b00;
    localparam logic [1:0] OP_B = 2'b01;
    localparam logic [1:0] OP_C = 2'b10;
    localparam logic [1:0] OP_D = 2'b11;

    typedef enum logic [1:0] {
        KC_DIGIT = 2'd0,
        KC_OPER  = 2'd1,
        KC_CLEAR = 2'd2,
        KC_ENTER = 2'd3
    } key_class_e;

    // val holds the BCD digit for KC_DIGIT, or the operator code in val[1:0]
    // for KC_OPER; it is zero for clear/enter.
    typedef struct packed {
        key_class_e cls;
        logic [3:0] val;
    } key_dec_t;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_HELD         = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } deb_state_e;

    // Keypad layout (row-major):
    //   1 2 3 A
    //   4 5 6 B
    //   7 8 9 C
    //   * 0 # D
    function automatic key_dec_t decode_key(input logic [3:0] pos);
        key_dec_t d;
        d.cls = KC_DIGIT;
        d.val = 4'd0;
        case (pos)
            4'd0:  d.val = 4'd1;
            4'd1:  d.val = 4'd2;
            4'd2:  d.val = 4'd3;
            4'd3:  begin d.cls = KC_OPER; d.val = {2'b00, OP_A}; end
            4'd4:  d.val = 4'd4;
            4'd5:  d.val = 4'd5;
            4'd6:  d.val = 4'd6;
            4'd7:  begin d.cls = KC_OPER; d.val = {2'b00, OP_B}; end
            4'd8:  d.val = 4'd7;
            4'd9:  d.val = 4'd8;
            4'd10: d.val = 4'd9;
            4'd11: begin d.cls = KC_OPER; d.val = {2'b00, OP_C}; end
            4'd12: d.cls = KC_CLEAR;
            4'd13: d.val = 4'd0;
            4'd14: d.cls = KC_ENTER;
            default: begin d.cls = KC_OPER; d.val = {2'b00, OP_D}; end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// ---------------------------------------------------------------------------
// key_debounce
// Turns the scanner's intermittent key-present flag into exactly one event
// per physical keystroke.
//   clk, rst   : system clock, asynchronous active-high reset
//   opr        : scanner key-present flag (high only when the scanned column
//                hits the key)
//   posicion   : scanner key position, stable while a key is held
//   key_evt    : one-cycle pulse per accepted keystroke
//   key_code   : position captured with the last event
// ---------------------------------------------------------------------------
module key_debounce
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       opr,
    input  logic [3:0] posicion,
    output logic       key_evt,
    output logic [3:0] key_code
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [3:0]    win_q;
    logic          pressed_raw;
    deb_state_e    state_q;
    logic [CW-1:0] cnt_q;
    logic          key_evt_q;
    logic [3:0]    key_code_q;

    // The scanner only asserts opr once per column sweep, so a held key looks
    // like a 1-in-4 pulse train; OR-ing the last four samples bridges the gaps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_q <= 4'b0000;
        end else begin
            win_q <= {win_q[2:0], opr};
        end
    end

    assign pressed_raw = |win_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            key_evt_q  <= 1'b0;
            key_code_q <= 4'd0;
        end else begin
            key_evt_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pressed_raw) begin
                        state_q <= ST_PRESS_WAIT;
                        cnt_q   <= CW'(1);
                    end
                end
                ST_PRESS_WAIT: begin
                    if (!pressed_raw) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q    <= ST_HELD;
                        key_evt_q  <= 1'b1;
                        key_code_q <= posicion;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_HELD: begin
                    if (!pressed_raw) begin
                        state_q <= ST_RELEASE_WAIT;
                        cnt_q   <= CW'(1);
                    end
                end
                ST_RELEASE_WAIT: begin
                    // A key seen again before release is confirmed is the
                    // same keystroke, so no new event.
                    if (pressed_raw) begin
                        state_q <= ST_HELD;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign key_evt  = key_evt_q;
    assign key_code = key_code_q;

endmodule

// File: rtl/key_entry.sv
// ---------------------------------------------------------------------------
// key_entry
// Keypad entry stage: debounces the scanner output and decodes each
// keystroke into a BCD digit buffer, an operator register, clear and enter.
//   clk, rst   : system clock, asynchronous active-high reset
//   opr        : scanner key-present flag
//   posicion   : scanner key position (row-major 0..15)
//   key_evt    : one-cycle pulse per accepted keystroke
//   key_code   : position of the current/last event
//   digits     : BCD buffer, digits[3:0] is the most recent digit
//   ndig       : number of digits entered
//   op         : latched operator code (A=00 .. D=11)
//   op_valid   : op set since the last clear
//   enter      : one-cycle pulse on '#'
//   overflow   : sticky, a digit arrived while the buffer was full
// ---------------------------------------------------------------------------
module key_entry
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int NDIG            = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         opr,
    input  logic [3:0]                   posicion,
    output logic                         key_evt,
    output logic [3:0]                   key_code,
    output logic [4*NDIG-1:0]            digits,
    output logic [$clog2(NDIG+1)-1:0]    ndig,
    output logic [1:0]                   op,
    output logic                         op_valid,
    output logic                         enter,
    output logic                         overflow
);

    localparam int DW = 4 * NDIG;
    localparam int NW = $clog2(NDIG + 1);

    logic          evt;
    logic [3:0]    code;
    key_dec_t      dec;

    logic [DW-1:0] digits_q,   digits_d;
    logic [NW-1:0] ndig_q,     ndig_d;
    logic [1:0]    op_q,       op_d;
    logic          op_valid_q, op_valid_d;
    logic          enter_q,    enter_d;
    logic          overflow_q, overflow_d;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk      (clk),
        .rst      (rst),
        .opr      (opr),
        .posicion (posicion),
        .key_evt  (evt),
        .key_code (code)
    );

    // key_code is already captured during the event cycle, so decoding the
    // registered code lets all updates land on the edge that ends it.
    assign dec = decode_key(code);

    always_comb begin
        digits_d   = digits_q;
        ndig_d     = ndig_q;
        op_d       = op_q;
        op_valid_d = op_valid_q;
        enter_d    = 1'b0;
        overflow_d = overflow_q;
        if (evt) begin
            case (dec.cls)
                KC_DIGIT: begin
                    if (ndig_q == NW'(NDIG)) begin
                        overflow_d = 1'b1;
                    end else begin
                        digits_d = (digits_q << 4) | DW'(dec.val);
                        ndig_d   = ndig_q + NW'(1);
                    end
                end
                KC_OPER: begin
                    op_d       = dec.val[1:0];
                    op_valid_d = 1'b1;
                end
                KC_CLEAR: begin
                    // op itself is deliberately kept; only its valid flag drops
                    digits_d   = '0;
                    ndig_d     = '0;
                    op_valid_d = 1'b0;
                    overflow_d = 1'b0;
                end
                default: begin
                    enter_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digits_q   <= '0;
            ndig_q     <= '0;
            op_q       <= 2'b00;
            op_valid_q <= 1'b0;
            enter_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            digits_q   <= digits_d;
            ndig_q     <= ndig_d;
            op_q       <= op_d;
            op_valid_q <= op_valid_d;
            enter_q    <= enter_d;
            overflow_q <= overflow_d;
        end
    end

    assign key_evt  = evt;
    assign key_code = code;
    assign digits   = digits_q;
    assign ndig     = ndig_q;
    assign op       = op_q;
    assign op_valid = op_valid_q;
    assign enter    = enter_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_key_entry.sv
// ---------------------------------------------------------------------------
// tb_key_entry
// Directed bench for key_entry (DEBOUNCE_CYCLES=4, NDIG=4). While a key is
// held, opr pulses one cycle in four, as the scanner does.
// With a 4-sample presence window and a 4-cycle debounce, any opr pulse keeps
// pressed_raw high long enough to be accepted, so short-burst rejection is
// exercised on a second instance with an 8-cycle debounce.
// ---------------------------------------------------------------------------
module tb_key_entry;

    localparam int DEB   = 4;
    localparam int DEB_S = 8;
    localparam int NDIG  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        opr;
    logic [3:0]  posicion;

    logic        key_evt,   key_evt_s;
    logic [3:0]  key_code,  key_code_s;
    logic [15:0] digits,    digits_s;
    logic [2:0]  ndig,      ndig_s;
    logic [1:0]  op,        op_s;
    logic        op_valid,  op_valid_s;
    logic        enter,     enter_s;
    logic        overflow,  overflow_s;

    key_entry #(.DEBOUNCE_CYCLES(DEB), .NDIG(NDIG)) dut (
        .clk(clk), .rst(rst), .opr(opr), .posicion(posicion),
        .key_evt(key_evt), .key_code(key_code), .digits(digits), .ndig(ndig),
        .op(op), .op_valid(op_valid), .enter(enter), .overflow(overflow)
    );

    key_entry #(.DEBOUNCE_CYCLES(DEB_S), .NDIG(NDIG)) dut_slow (
        .clk(clk), .rst(rst), .opr(opr), .posicion(posicion),
        .key_evt(key_evt_s), .key_code(key_code_s), .digits(digits_s), .ndig(ndig_s),
        .op(op_s), .op_valid(op_valid_s), .enter(enter_s), .overflow(overflow_s)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Event monitor, sampled 1 time unit after each rising edge.
    int          cyc        = 0;
    int          evt_cnt    = 0;
    int          evt_cyc    = 0;
    int          enter_cnt  = 0;
    int          long_pulse = 0;
    int          evt_s_cnt  = 0;
    logic [15:0] evt_digits = '0;
    logic        prev_evt   = 1'b0;
    logic        prev_enter = 1'b0;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (key_evt) begin
            evt_cnt++;
            evt_cyc    = cyc;
            evt_digits = digits;
        end
        if (key_evt && prev_evt) long_pulse++;
        if (enter) enter_cnt++;
        if (enter && prev_enter) long_pulse++;
        if (key_evt_s) evt_s_cnt++;
        prev_evt   = key_evt;
        prev_enter = enter;
    end

    // Hold a key for 'hold' cycles with 1-in-4 opr pulses, then release.
    task automatic press(input logic [3:0] pos, input int hold, input int rel);
        posicion = pos;
        for (int i = 0; i < hold; i++) begin
            opr = (i % 4 == 0);
            @(negedge clk);
        end
        opr = 1'b0;
        repeat (rel) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    int c0, e0, en0;
    logic [3:0] fill_keys [4] = '{4'd0, 4'd1, 4'd2, 4'd4};

    initial begin
        rst      = 1'b1;
        opr      = 1'b0;
        posicion = 4'd0;
        repeat (2) @(negedge clk);
        chk("reset_state", {key_evt, key_code, digits, ndig, op, op_valid, enter, overflow}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single digit: posicion 5 held 20 cycles
        c0 = cyc;
        e0 = evt_cnt;
        press(4'd5, 20, 12);
        chk("single_evt_count",   evt_cnt - e0, 1);
        chk("single_evt_latency", evt_cyc - c0, 5);
        chk("single_buf_in_evt",  evt_digits, 16'h0000);
        chk("single_key_code",    key_code, 4'd5);
        chk("single_digits",      digits, 16'h0005);
        chk("single_ndig",        ndig, 3'd1);
        chk("single_long_pulse",  long_pulse, 0);

        // Asynchronous reset mid-run: outputs clear before any clock edge
        #2 rst = 1'b1;
        #1;
        chk("reset_async", {key_evt, key_code, digits, ndig, op, op_valid, enter, overflow}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Bounce: 2 cycles of opr then 10 quiet cycles (clear key on the
        // main instance, which is harmless on an empty buffer)
        e0       = evt_s_cnt;
        posicion = 4'd12;
        opr      = 1'b1;
        repeat (2) @(negedge clk);
        opr = 1'b0;
        repeat (10) @(negedge clk);
        chk("bounce_no_evt", evt_s_cnt - e0, 0);
        chk("bounce_state_unchanged",
            {key_evt_s, key_code_s, digits_s, ndig_s, op_s, op_valid_s, enter_s, overflow_s}, 32'd0);
        chk("bounce_main_digits", digits, 16'h0000);

        // Fill the buffer with 1,2,3,4 then overflow with 5
        foreach (fill_keys[k]) press(fill_keys[k], 20, 12);
        chk("fill_digits",   digits, 16'h1234);
        chk("fill_ndig",     ndig, 3'd4);
        chk("fill_no_ovf",   overflow, 1'b0);
        press(4'd5, 20, 12);
        chk("ovf_digits",    digits, 16'h1234);
        chk("ovf_ndig",      ndig, 3'd4);
        chk("ovf_flag",      overflow, 1'b1);

        // Operators and clear
        press(4'd3, 20, 12);
        chk("op_a_code",     op, 2'b00);
        chk("op_a_valid",    op_valid, 1'b1);
        press(4'd15, 20, 12);
        chk("op_d_code",     op, 2'b11);
        press(4'd12, 20, 12);
        chk("clr_digits",    digits, 16'h0000);
        chk("clr_ndig",      ndig, 3'd0);
        chk("clr_op_valid",  op_valid, 1'b0);
        chk("clr_overflow",  overflow, 1'b0);
        chk("clr_op_kept",   op, 2'b11);

        // Digit 7 then enter
        press(4'd8, 20, 12);
        en0 = enter_cnt;
        press(4'd14, 20, 12);
        chk("enter_count",   enter_cnt - en0, 1);
        chk("enter_digits",  digits, 16'h0007);
        chk("enter_ndig",    ndig, 3'd1);
        chk("enter_code",    key_code, 4'd14);
        chk("pulse_width",   long_pulse, 0);

        // Reset during PRESS_WAIT, key stays held afterwards
        e0       = evt_cnt;
        posicion = 4'd5;
        opr      = 1'b1;
        @(negedge clk);
        opr = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        #2 rst = 1'b0;
        chk("rstpress_no_evt", evt_cnt - e0, 0);
        @(negedge clk);
        c0 = cyc;
        press(4'd5, 20, 12);
        chk("rstpress_one_evt",  evt_cnt - e0, 1);
        chk("rstpress_latency",  evt_cyc - c0, 5);
        chk("rstpress_digits",   digits, 16'h0005);
        chk("rstpress_ndig",     ndig, 3'd1);
        chk("rstpress_code",     key_code, 4'd5);
        chk("rstpress_pulse",    long_pulse, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
